// File: rtl/uart_pkg.sv
// Shared UART definitions: default generator widths, the divisor record and a
// helper that derives an integer-plus-fraction divisor from clock and baud rates.
package uart_pkg;

    localparam int DEFAULT_DIVISOR_WIDTH = 16;
    localparam int DEFAULT_FRAC_WIDTH    = 4;
    localparam int DEFAULT_OVERSAMPLE    = 16;

    typedef struct packed {
        logic [DEFAULT_DIVISOR_WIDTH-1:0] divInt;
        logic [DEFAULT_FRAC_WIDTH-1:0]    divFrac;
    } baud_divisor_t;

    // Rounds clkHz / (baudHz * OVERSAMPLE) to the nearest 1/2^FRAC_WIDTH cycle.
    function automatic baud_divisor_t computeDivisor(input longint unsigned clkHz,
                                                     input longint unsigned baudHz);
        longint unsigned denom;
        longint unsigned scaled;
        baud_divisor_t   result;
        denom = baudHz * 64'(DEFAULT_OVERSAMPLE);
        if (denom == 64'd0) begin
            denom = 64'd1;
        end
        scaled = ((clkHz << DEFAULT_FRAC_WIDTH) + (denom >> 1)) / denom;
        result.divInt  = scaled[DEFAULT_FRAC_WIDTH +: DEFAULT_DIVISOR_WIDTH];
        result.divFrac = scaled[DEFAULT_FRAC_WIDTH-1:0];
        return result;
    endfunction

endpackage

// File: rtl/uart_frac_accumulator.sv
// Fractional phase accumulator: its overflow stretches the current sample
// period by one clock. Only instantiated when UART_BAUD_FRACTIONAL_EN is defined.
module uart_frac_accumulator
    import uart_pkg::*;
#(
    parameter int FRAC_WIDTH = DEFAULT_FRAC_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  advance_i,
    input  logic [FRAC_WIDTH-1:0] frac_i,
    output logic                  carry_o
);

    logic [FRAC_WIDTH-1:0] acc_q;
    logic [FRAC_WIDTH-1:0] acc_d;
    logic [FRAC_WIDTH:0]   sum;

    assign sum     = {1'b0, acc_q} + {1'b0, frac_i};
    assign carry_o = sum[FRAC_WIDTH];

    // A divisor change or phase restart wins over a normal period advance.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (advance_i) begin
            acc_d = sum[FRAC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/uart_baud_generator.sv
// Programmable baud tick generator producing sample/bit/mid-bit strobes.
// Fractional divisor support is compiled in with UART_BAUD_FRACTIONAL_EN.
module uart_baud_generator
    import uart_pkg::*;
#(
    parameter int DIVISOR_WIDTH = DEFAULT_DIVISOR_WIDTH,
    parameter int FRAC_WIDTH    = DEFAULT_FRAC_WIDTH,
    parameter int OVERSAMPLE    = DEFAULT_OVERSAMPLE,
    parameter int RESET_DIVISOR = 16
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     sync,
    input  logic [DIVISOR_WIDTH-1:0] divisor_int,
    input  logic [FRAC_WIDTH-1:0]    divisor_frac,
    input  logic                     divisor_valid,
    output logic                     divisor_ready,
    output logic                     sample_tick,
    output logic                     bit_tick,
    output logic                     mid_tick
);

    localparam int SAMPLE_WIDTH = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [SAMPLE_WIDTH-1:0] LAST_SAMPLE = SAMPLE_WIDTH'(OVERSAMPLE - 1);
    localparam logic [SAMPLE_WIDTH-1:0] MID_SAMPLE  = SAMPLE_WIDTH'(OVERSAMPLE / 2);

    logic [DIVISOR_WIDTH-1:0] activeInt_q, activeInt_d;
    logic [DIVISOR_WIDTH-1:0] stageInt_q, stageInt_d;
    logic [DIVISOR_WIDTH-1:0] cycleCount_q, cycleCount_d;
    logic [SAMPLE_WIDTH-1:0]  sampleCount_q, sampleCount_d;
    logic                     pending_q, pending_d;
    logic                     sampleTick_q, sampleTick_d;
    logic                     bitTick_q, bitTick_d;
    logic                     midTick_q, midTick_d;

    logic [DIVISOR_WIDTH-1:0] effInt;
    logic [DIVISOR_WIDTH-1:0] lastCount;
    logic [SAMPLE_WIDTH-1:0]  sampleNext;
    logic                     carry;
    logic                     wrap;
    logic                     accept;
    logic                     activate;

    // A zero divisor behaves as one so the counter always has a terminal value.
    assign effInt     = (activeInt_q == '0) ? DIVISOR_WIDTH'(1) : activeInt_q;
    assign lastCount  = effInt - DIVISOR_WIDTH'(1) + DIVISOR_WIDTH'(carry);
    assign wrap       = enable && !sync && (cycleCount_q == lastCount);
    assign accept     = divisor_valid && !pending_q;
    assign activate   = pending_q && (sync || !enable || wrap);
    assign sampleNext = (sampleCount_q == LAST_SAMPLE) ? '0 : sampleCount_q + SAMPLE_WIDTH'(1);

`ifdef UART_BAUD_FRACTIONAL_EN
    logic [FRAC_WIDTH-1:0] activeFrac_q, activeFrac_d;
    logic [FRAC_WIDTH-1:0] stageFrac_q, stageFrac_d;

    always_comb begin
        activeFrac_d = activeFrac_q;
        stageFrac_d  = stageFrac_q;
        if (activate) begin
            activeFrac_d = stageFrac_q;
        end else if (accept) begin
            stageFrac_d = divisor_frac;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            activeFrac_q <= '0;
            stageFrac_q  <= '0;
        end else begin
            activeFrac_q <= activeFrac_d;
            stageFrac_q  <= stageFrac_d;
        end
    end

    uart_frac_accumulator #(
        .FRAC_WIDTH(FRAC_WIDTH)
    ) u_fracAcc (
        .clk_in   (clk_in),
        .rst      (rst),
        .clear_i  (sync || activate),
        .advance_i(wrap),
        .frac_i   (activeFrac_q),
        .carry_o  (carry)
    );
`else
    logic unusedFrac;
    assign unusedFrac = ^divisor_frac;
    assign carry      = 1'b0;
`endif

    // sync overrides everything; a disabled generator freezes its counters.
    always_comb begin
        cycleCount_d  = cycleCount_q;
        sampleCount_d = sampleCount_q;
        sampleTick_d  = 1'b0;
        bitTick_d     = 1'b0;
        midTick_d     = 1'b0;
        activeInt_d   = activeInt_q;
        stageInt_d    = stageInt_q;
        pending_d     = pending_q;

        if (sync) begin
            cycleCount_d  = '0;
            sampleCount_d = '0;
        end else if (enable) begin
            if (wrap) begin
                cycleCount_d  = '0;
                sampleCount_d = sampleNext;
                sampleTick_d  = 1'b1;
                bitTick_d     = (sampleCount_q == LAST_SAMPLE);
                midTick_d     = (sampleNext == MID_SAMPLE);
            end else begin
                cycleCount_d = cycleCount_q + DIVISOR_WIDTH'(1);
            end
        end

        if (activate) begin
            activeInt_d = stageInt_q;
            pending_d   = 1'b0;
        end else if (accept) begin
            stageInt_d = divisor_int;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            activeInt_q   <= DIVISOR_WIDTH'(RESET_DIVISOR);
            stageInt_q    <= '0;
            cycleCount_q  <= '0;
            sampleCount_q <= '0;
            pending_q     <= 1'b0;
            sampleTick_q  <= 1'b0;
            bitTick_q     <= 1'b0;
            midTick_q     <= 1'b0;
        end else begin
            activeInt_q   <= activeInt_d;
            stageInt_q    <= stageInt_d;
            cycleCount_q  <= cycleCount_d;
            sampleCount_q <= sampleCount_d;
            pending_q     <= pending_d;
            sampleTick_q  <= sampleTick_d;
            bitTick_q     <= bitTick_d;
            midTick_q     <= midTick_d;
        end
    end

    assign divisor_ready = !pending_q;
    assign sample_tick   = sampleTick_q;
    assign bit_tick      = bitTick_q;
    assign mid_tick      = midTick_q;

endmodule

// File: doc/uart_baud_generator.md
# uart_baud_generator

Programmable baud-rate tick generator for the UART, succeeding the fixed-divisor sample clock divider. It produces single-cycle sample strobes with a runtime-loadable integer-plus-fractional divisor, plus bit-rate and mid-bit strobes derived from a configurable oversampling ratio. The transmitter and receiver in the UART peripheral consume it, and the receiver can resynchronise its phase on start-bit detection. All outputs are clock-enable strobes, never clocks.

## Interface
- DIVISOR_WIDTH, 16, width of the integer divisor
- FRAC_WIDTH, 4, width of the fractional divisor (LSB = 1/2^FRAC_WIDTH cycle)
- OVERSAMPLE, 16, sample strobes per bit; must be ≥2
- RESET_DIVISOR, 16, integer divisor loaded at reset; fraction resets to 0
- clk_in  input  1  clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  high: generator runs; low: all counters hold, strobes low
- sync  input  1  phase restart pulse (receiver start-bit alignment)
- divisor_int  input  DIVISOR_WIDTH  requested integer divisor
- divisor_frac  input  FRAC_WIDTH  requested fractional divisor
- divisor_valid  input  1  request to load divisor_int/divisor_frac
- divisor_ready  output  1  high when a new divisor can be accepted
- sample_tick  output  1  one-cycle strobe at the oversampled rate
- bit_tick  output  1  one-cycle strobe every OVERSAMPLE sample_ticks
- mid_tick  output  1  one-cycle strobe at sample OVERSAMPLE/2 of each bit

## Operation
- Reset values: active divisor = RESET_DIVISOR.0, cycle counter 0, fraction accumulator 0, sample counter 0, pending flag 0. divisor_ready = 1. sample_tick, bit_tick and mid_tick = 0.
- Period: the cycle counter counts 0..P-1. P = div_int + carry, where carry is the overflow of frac_acc + div_frac (FRAC_WIDTH bits, wraps) computed at each wrap. An effective div_int of 0 is treated as 1.
- Wrap: when the counter equals P-1, the counter goes to 0, the accumulator updates, and sample_tick is registered high for the next cycle.
- The sample counter counts 0..OVERSAMPLE-1 on each sample_tick.
  - bit_tick coincides with the sample_tick that takes the counter from OVERSAMPLE-1 to 0.
  - mid_tick coincides with the sample_tick that takes the counter to OVERSAMPLE/2.
- Load handshake: divisor_ready = !pending. The divisor is accepted on a clock edge with valid && ready; the values are latched into a staging register and pending is set.
  - The staged values become active on the first wrap strictly after acceptance, or on the next edge if enable is low. At that point frac_acc clears and pending clears.
  - valid while ready is low is ignored, and the master must hold its values.
- sync: has priority over wrap and enable. It clears the cycle counter, frac_acc and the sample counter, and forces all strobes low that cycle. If pending is set, the staged divisor activates at sync.
- enable low: the counter, accumulator and sample counter hold. Strobes stay low. Re-enabling resumes from the held count.
- Reset mid-operation: everything returns to its reset values immediately, and any staged divisor is discarded.

## Timing
- Strobes are registered outputs with no combinational path from inputs.
- Cycle convention: cycle 0 is the first edge after rst deasserts, with enable high.
  - With integer divisor D, sample_tick is high after the D-th rising edge, then every D cycles.
  - The first bit_tick comes with the OVERSAMPLE-th sample_tick.
  - The first mid_tick comes with the (OVERSAMPLE/2)-th sample_tick.
- After sync on edge n, the next sample_tick is high after edge n+D.
- Fractional divisor D.f: over 2^FRAC_WIDTH sample periods, exactly f periods are D+1 cycles long and the rest are D. The long period occurs when the accumulator carries.
- divisor_ready drops the cycle after acceptance and rises the cycle after activation.

## Configuration
- UART_BAUD_FRACTIONAL_EN defined: the fractional accumulator is present and behaves as described above.
- Macro not defined:
  - divisor_frac is ignored and the accumulator is removed.
  - carry is always 0, so periods are exactly div_int.
  - The ports stay present for interface stability.

## Structure
- The shared package uart_pkg holds:
  - the default DIVISOR_WIDTH, FRAC_WIDTH and OVERSAMPLE constants;
  - a baud_divisor_t struct {int, frac};
  - a helper function computing the divisor from clock and baud frequencies.
- One natural sub-module, uart_frac_accumulator, owns the fraction accumulator and carry generation. It is instantiated only under UART_BAUD_FRACTIONAL_EN.

## Test plan
- Reset with defaults (D=16, OVERSAMPLE=16), enable high: sample_tick pulses at edges 16, 32, 48; the first bit_tick is at edge 256 and the first mid_tick at edge 128; every strobe is exactly one cycle wide.
- Load 10.8 (FRAC_WIDTH=4, frac=8): after activation, periods alternate 10/11 cycles, so 16 ticks take exactly 168 cycles.
- Load divisor 5 mid-period at counter value 3 of D=16: the current period completes at 16 cycles, subsequent periods are 5 cycles, and divisor_ready is low from acceptance until activation. A second valid during pending is not accepted.
- Pulse sync at counter 9 with sample counter 7: no strobe that cycle; the next sample_tick comes 16 edges later and the next bit_tick after 16 further sample_ticks.
- Drop enable for 20 cycles at counter 4, then raise it: no strobes while low; the next tick comes 12 cycles after re-enable. Assert rst mid-period: all outputs go to 0 immediately and staged values are discarded.
- Load div_int=0 and div_int=1: sample_tick is high every cycle; bit_tick fires every OVERSAMPLE cycles.
